// File: rtl/fpu_issue_queue.sv
// In-order FP issue queue: filters FP opcodes from the core offer and buffers them for a single FPU.
// Optional duplicate-id detection is enabled by defining RVFPM_ISSUE_ID_CHECK_EN.
module fpu_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [31:0]           issue_rs0,
  output logic                  issue_accept,
  input  logic                  flush,
  input  logic                  fpu_ready,
  output logic                  fpu_enable,
  output logic [31:0]           fpu_instruction,
  output logic [X_ID_WIDTH-1:0] fpu_id,
  output logic [31:0]           fpu_data_fromXreg,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                  id_conflict
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]           instr;
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rs0;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  always_comb begin
    issue_accept = 1'b0;
    case (issue_instr[6:0])
      7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111,
      7'b1001011, 7'b1001111, 7'b1010011: issue_accept = 1'b1;
      default:                            issue_accept = 1'b0;
    endcase
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // rst gating keeps the handshake closed while the reset is held low
  assign issue_ready = rst && !flush && (!full || !issue_accept);
  assign push        = issue_valid && issue_ready && issue_accept;
  assign fpu_enable  = rst && !empty && fpu_ready && !flush;
  assign pop         = fpu_enable;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge ck) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: issue_instr, id: issue_id, rs0: issue_rs0};
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign {fpu_instruction, fpu_id, fpu_data_fromXreg} = empty ? '0 : head;

`ifdef RVFPM_ISSUE_ID_CHECK_EN
  logic          id_conflict_q, id_conflict_d, id_match;
  logic [PW-1:0] off;

  // An entry is live when its distance from the read pointer is below count
  always_comb begin
    id_match = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ((CW'(off) < count_q) && (mem_q[i].id == issue_id)) id_match = 1'b1;
    end
    id_conflict_d = id_conflict_q || (push && id_match);
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) id_conflict_q <= 1'b0;
    else      id_conflict_q <= id_conflict_d;
  end

  assign id_conflict = id_conflict_q;
`else
  assign id_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fpu_issue_queue;
  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam logic [31:0] FADD = 32'h0020_8053;

  logic            ck = 1'b0;
  logic            rst = 1'b0;
  logic            issue_valid = 1'b0;
  logic            flush = 1'b0;
  logic            fpu_ready = 1'b0;
  logic [31:0]     issue_instr = '0;
  logic [31:0]     issue_rs0 = '0;
  logic [IDW-1:0]  issue_id = '0;
  logic            issue_ready, issue_accept, fpu_enable, id_conflict;
  logic [31:0]     fpu_instruction, fpu_data_fromXreg;
  logic [IDW-1:0]  fpu_id;
  logic [2:0]      count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic [31:0]    rs0;
  } ent_t;

  ent_t mq[$];
  logic m_conflict;

  fpu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW)) dut (
    .ck(ck), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_id(issue_id), .issue_rs0(issue_rs0),
    .issue_accept(issue_accept), .flush(flush), .fpu_ready(fpu_ready),
    .fpu_enable(fpu_enable), .fpu_instruction(fpu_instruction), .fpu_id(fpu_id),
    .fpu_data_fromXreg(fpu_data_fromXreg), .count(count), .id_conflict(id_conflict)
  );

  always #5 ck = ~ck;

  function automatic logic is_fp(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    return op inside {7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53};
  endfunction

  function automatic logic exp_conflict(input logic flag);
`ifdef RVFPM_ISSUE_ID_CHECK_EN
    return flag;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock; leaves time at negedge+1, the drive point
  task automatic next_cycle();
    @(posedge ck);
    @(negedge ck);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; flush = 1'b0; fpu_ready = 1'b0;
    issue_instr = '0; issue_id = '0; issue_rs0 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    issue_valid = 1'b1; issue_instr = FADD; fpu_ready = 1'b1;
    #2;
    checks++;
    if (count !== 3'd0 || issue_ready !== 1'b0 || fpu_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl count=%0d ready=%b en=%b expected 0/0/0", count, issue_ready, fpu_enable);
    end
    checks++;
    if (fpu_instruction !== '0 || fpu_id !== '0 || fpu_data_fromXreg !== '0 || id_conflict !== 1'b0) begin
      failures++;
      $display("FAIL reset_data instr=%h id=%h data=%h conf=%b expected zeros",
               fpu_instruction, fpu_id, fpu_data_fromXreg, id_conflict);
    end
    next_cycle();
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL reset_no_push count=%0d expected 0", count);
    end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_fadd();
    issue_valid = 1'b1; issue_instr = FADD; issue_id = 4'd3; issue_rs0 = 32'hCAFE_0001; fpu_ready = 1'b1;
    #1;
    checks++;
    if (issue_accept !== 1'b1 || issue_ready !== 1'b1 || fpu_enable !== 1'b0) begin
      failures++;
      $display("FAIL fadd_offer acc=%b rdy=%b en=%b expected 1/1/0", issue_accept, issue_ready, fpu_enable);
    end
    next_cycle();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (fpu_enable !== 1'b1 || fpu_id !== 4'd3 || count !== 3'd1 ||
        fpu_instruction !== FADD || fpu_data_fromXreg !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL fadd_present en=%b id=%0d cnt=%0d instr=%h data=%h expected 1/3/1/%h/cafe0001",
               fpu_enable, fpu_id, count, fpu_instruction, fpu_data_fromXreg, FADD);
    end
    next_cycle();
    #1;
    checks++;
    if (count !== 3'd0 || fpu_enable !== 1'b0 || fpu_id !== '0) begin
      failures++;
      $display("FAIL fadd_popped cnt=%0d en=%b id=%0d expected 0/0/0", count, fpu_enable, fpu_id);
    end
    idle_inputs();
  endtask

  task automatic test_non_fp();
    issue_valid = 1'b1; issue_instr = 32'h0000_0033; issue_id = 4'd1; fpu_ready = 1'b1;
    #1;
    checks++;
    if (issue_accept !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL nonfp_offer acc=%b rdy=%b expected 0/1", issue_accept, issue_ready);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      checks++;
      if (count !== 3'd0 || fpu_enable !== 1'b0) begin
        failures++;
        $display("FAIL nonfp_drop cyc=%0d cnt=%0d en=%b expected 0/0", k, count, fpu_enable);
      end
    end
    idle_inputs();
  endtask

  task automatic test_fill_and_full_pop();
    int exp_cnt[5] = '{4, 3, 3, 2, 1};
    fpu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue_valid = 1'b1; issue_instr = FADD; issue_id = IDW'(k); issue_rs0 = 32'(k);
      #1;
      checks++;
      if (issue_ready !== (k < 4) || (k == 4 && count !== 3'd4) || (k >= 1 && fpu_id !== 4'd0)) begin
        failures++;
        $display("FAIL fill k=%0d rdy=%b cnt=%0d head=%0d expected rdy=%b head=0", k, issue_ready, count, fpu_id, k < 4);
      end
      next_cycle();
    end
    fpu_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++;
      if (fpu_enable !== 1'b1 || fpu_id !== IDW'(j) || count !== 3'(exp_cnt[j]) ||
          (j == 0 && issue_ready !== 1'b0) || (j == 1 && issue_ready !== 1'b1)) begin
        failures++;
        $display("FAIL drain j=%0d en=%b id=%0d cnt=%0d rdy=%b expected 1/%0d/%0d", j, fpu_enable, fpu_id, count,
                 issue_ready, j, exp_cnt[j]);
      end
      next_cycle();
      if (j == 1) issue_valid = 1'b0;
    end
    #1;
    checks++;
    if (count !== 3'd0 || fpu_enable !== 1'b0) begin
      failures++;
      $display("FAIL drain_end cnt=%0d en=%b expected 0/0", count, fpu_enable);
    end
    idle_inputs();
  endtask

  task automatic test_flush_and_reset();
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_instr = FADD; issue_id = IDW'(7 + k);
      next_cycle();
    end
    flush = 1'b1; fpu_ready = 1'b1; issue_id = 4'd2;
    #1;
    checks++;
    if (issue_ready !== 1'b0 || fpu_enable !== 1'b0 || count !== 3'd3) begin
      failures++;
      $display("FAIL flush_cycle rdy=%b en=%b cnt=%0d expected 0/0/3", issue_ready, fpu_enable, count);
    end
    next_cycle();
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || fpu_enable !== 1'b0 || fpu_id !== '0) begin
      failures++;
      $display("FAIL flush_after cnt=%0d en=%b id=%0d expected 0/0/0", count, fpu_enable, fpu_id);
    end
    fpu_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_instr = FADD; issue_id = IDW'(10 + k); issue_rs0 = 32'h55;
      next_cycle();
    end
    issue_valid = 1'b0; fpu_ready = 1'b1;
    #1;
    checks++;
    if (fpu_enable !== 1'b1 || fpu_id !== 4'd10) begin
      failures++;
      $display("FAIL middrain_head en=%b id=%0d expected 1/10", fpu_enable, fpu_id);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || fpu_enable !== 1'b0 || fpu_id !== '0 || fpu_instruction !== '0 ||
        fpu_data_fromXreg !== '0 || issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset cnt=%0d en=%b id=%0d instr=%h rdy=%b expected zeros",
               count, fpu_enable, fpu_id, fpu_instruction, issue_ready);
    end
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (fpu_enable !== 1'b0 || count !== 3'd0) begin
        failures++;
        $display("FAIL post_reset k=%0d en=%b cnt=%0d expected 0/0", k, fpu_enable, count);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_id_conflict();
    do_reset();
    issue_valid = 1'b1; issue_instr = FADD; issue_id = 4'd5;
    next_cycle();
    #1;
    checks++;
    if (id_conflict !== 1'b0) begin
      failures++;
      $display("FAIL idc_first got=%b expected 0", id_conflict);
    end
    next_cycle();
    issue_valid = 1'b0;
    #1;
    checks++;
    if (id_conflict !== exp_conflict(1'b1)) begin
      failures++;
      $display("FAIL idc_dup got=%b expected %b", id_conflict, exp_conflict(1'b1));
    end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    next_cycle();
    checks++;
    if (id_conflict !== exp_conflict(1'b1)) begin
      failures++;
      $display("FAIL idc_sticky got=%b expected %b", id_conflict, exp_conflict(1'b1));
    end
    do_reset();
    #1;
    checks++;
    if (id_conflict !== 1'b0) begin
      failures++;
      $display("FAIL idc_cleared got=%b expected 0", id_conflict);
    end
  endtask

  task automatic test_random();
    logic [6:0]  fp_ops[7] = '{7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53};
    logic [31:0] r;
    logic        e_acc, e_rdy, e_en, e_push;
    ent_t        e_head;
    do_reset();
    mq.delete();
    m_conflict = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[6:0] = fp_ops[$urandom_range(0, 6)];
      issue_instr = r;
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_id    = IDW'($urandom);
      issue_rs0   = $urandom;
      flush       = ($urandom_range(0, 19) == 0);
      fpu_ready   = ($urandom_range(0, 1) == 1);
      #1;
      e_acc  = is_fp(issue_instr);
      e_rdy  = !flush && !(mq.size() == DEPTH && e_acc);
      e_en   = (mq.size() > 0) && fpu_ready && !flush;
      e_head = (mq.size() > 0) ? mq[0] : '0;
      e_push = issue_valid && e_rdy && e_acc;
      checks++;
      if (issue_accept !== e_acc || issue_ready !== e_rdy || fpu_enable !== e_en || count !== 3'(mq.size())) begin
        failures++;
        $display("FAIL rand_ctrl c=%0d acc=%b rdy=%b en=%b cnt=%0d expected %b/%b/%b/%0d",
                 c, issue_accept, issue_ready, fpu_enable, count, e_acc, e_rdy, e_en, mq.size());
      end
      checks++;
      if ({fpu_instruction, fpu_id, fpu_data_fromXreg} !== e_head || id_conflict !== exp_conflict(m_conflict)) begin
        failures++;
        $display("FAIL rand_data c=%0d head=%h conf=%b expected %h/%b",
                 c, {fpu_instruction, fpu_id, fpu_data_fromXreg}, id_conflict, e_head, exp_conflict(m_conflict));
      end
      if (e_push) foreach (mq[i]) if (mq[i].id == issue_id) m_conflict = 1'b1;
      if (flush) mq.delete();
      else begin
        if (e_en) void'(mq.pop_front());
        if (e_push) mq.push_back('{instr: issue_instr, id: issue_id, rs0: issue_rs0});
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_non_fp();
    test_fill_and_full_pop();
    test_flush_and_reset();
    test_id_conflict();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
